// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues single-outstanding word reads to the instruction RAM and
// buffers returned instructions, tagged with their PC, in a small prefetch queue for decode.
module fetch_unit #(
  parameter int unsigned PC_W   = 8,
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic [15:0]       mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_data,
  output logic [PC_W-1:0]   instr_pc,
  output logic [3:0]        q_count
);

  typedef enum logic [1:0] {StLoad, StFetch, StWait} state_e;

  state_e            state_q;
  logic [PC_W-1:0]   fetch_pc_q;
  logic [PC_W-1:0]   req_pc_q;
  logic              outstanding_q;
  logic              discard_q;

  logic [DATA_W-1:0] q_data_q [DEPTH];
  logic [DATA_W-1:0] q_data_d [DEPTH];
  logic [PC_W-1:0]   q_pc_q   [DEPTH];
  logic [PC_W-1:0]   q_pc_d   [DEPTH];
  logic [3:0]        count_q;
  logic [3:0]        count_d;
  logic [3:0]        wr_idx;

  logic room;
  logic accept;
  logic push;
  logic pop;

  assign room    = (count_q + 4'(outstanding_q)) < 4'(DEPTH);
  assign mem_req = (state_q == StFetch) && room && !redirect_valid;
  // Address bus holds the last issued PC whenever no request is being made.
  assign mem_addr = 16'(mem_req ? fetch_pc_q : req_pc_q);

  assign accept = (state_q == StWait) && outstanding_q && mem_rvalid;
  assign push   = accept && !discard_q && !redirect_valid;
  assign pop    = instr_valid && instr_ready && !redirect_valid;

  assign instr_valid = (count_q != 4'd0);
  assign instr_data  = q_data_q[0];
  assign instr_pc    = q_pc_q[0];
  assign q_count     = count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StLoad;
      fetch_pc_q    <= '0;
      req_pc_q      <= '0;
      outstanding_q <= 1'b0;
      discard_q     <= 1'b0;
    end else begin
      case (state_q)
        StLoad: state_q <= StFetch;
        StFetch: begin
          if (mem_req) begin
            req_pc_q      <= fetch_pc_q;
            fetch_pc_q    <= fetch_pc_q + 1'b1;
            outstanding_q <= 1'b1;
            state_q       <= StWait;
          end
        end
        StWait: begin
          if (accept) begin
            outstanding_q <= 1'b0;
            discard_q     <= 1'b0;
            state_q       <= StFetch;
          end
        end
        default: state_q <= StLoad;
      endcase
      // Redirect overrides whatever the state decode chose above.
      if (redirect_valid) begin
        fetch_pc_q <= redirect_pc;
        if (outstanding_q && !mem_rvalid) begin
          discard_q <= 1'b1;
          state_q   <= StWait;
        end else begin
          outstanding_q <= 1'b0;
          discard_q     <= 1'b0;
          state_q       <= StFetch;
        end
      end
    end
  end

  // Shift-register queue: entry 0 is always the head, so the head outputs come straight
  // from flops and stay stable under backpressure.
  always_comb begin
    q_data_d = q_data_q;
    q_pc_d   = q_pc_q;
    count_d  = count_q;
    wr_idx   = count_q;
    if (redirect_valid) begin
      count_d = '0;
    end else begin
      if (pop) begin
        for (int i = 0; i < int'(DEPTH) - 1; i++) begin
          q_data_d[i] = q_data_q[i+1];
          q_pc_d[i]   = q_pc_q[i+1];
        end
        wr_idx = count_q - 4'd1;
      end
      if (push) begin
        for (int i = 0; i < int'(DEPTH); i++) begin
          if (4'(i) == wr_idx) begin
            q_data_d[i] = mem_rdata;
            q_pc_d[i]   = req_pc_q;
          end
        end
      end
      count_d = count_q + 4'(push) - 4'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        q_data_q[i] <= '0;
        q_pc_q[i]   <= '0;
      end
    end else begin
      count_q  <= count_d;
      q_data_q <= q_data_d;
      q_pc_q   <= q_pc_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a behavioural instruction RAM returning 0xA0000000 + addr
// after a programmable latency, with request and delivery logs checked against hand values.
module tb_fetch_unit;

  localparam int unsigned PC_W   = 8;
  localparam int unsigned DEPTH  = 2;
  localparam int unsigned DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              mem_req;
  logic [15:0]       mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_rvalid;
  logic              redirect_valid;
  logic [PC_W-1:0]   redirect_pc;
  logic              instr_valid;
  logic              instr_ready;
  logic [DATA_W-1:0] instr_data;
  logic [PC_W-1:0]   instr_pc;
  logic [3:0]        q_count;

  int n_checks = 0;
  int n_errors = 0;

  int          lat  = 1;
  bit          mute = 1'b0;
  bit          pend = 1'b0;
  int          cnt  = 0;
  logic [15:0] pend_addr;
  logic        req_seen;
  logic [15:0] addr_seen;

  logic [15:0]       req_log  [$];
  logic [PC_W-1:0]   got_pc   [$];
  logic [DATA_W-1:0] got_data [$];

  fetch_unit #(.PC_W(PC_W), .DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_rdata      (mem_rdata),
    .mem_rvalid     (mem_rvalid),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .q_count        (q_count)
  );

  always #5 clk = ~clk;

  // Memory model and logs: sample pre-edge values, respond 1 time unit after the edge.
  always @(posedge clk) begin
    req_seen  = mem_req;
    addr_seen = mem_addr;
    if (mem_req) req_log.push_back(mem_addr);
    if (rst && instr_valid && instr_ready && !redirect_valid) begin
      got_pc.push_back(instr_pc);
      got_data.push_back(instr_data);
    end
    #1;
    if (!mute) begin
      mem_rvalid = 1'b0;
      if (req_seen) begin
        pend      = 1'b1;
        pend_addr = addr_seen;
        cnt       = lat;
      end
      if (pend) begin
        cnt = cnt - 1;
        if (cnt == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = 32'hA000_0000 + 32'(pend_addr);
          pend       = 1'b0;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] req_at(input int i);
    return (i < req_log.size()) ? 64'(req_log[i]) : '1;
  endfunction

  function automatic logic [63:0] pc_at(input int i);
    return (i < got_pc.size()) ? 64'(got_pc[i]) : '1;
  endfunction

  function automatic logic [63:0] data_at(input int i);
    return (i < got_data.size()) ? 64'(got_data[i]) : '1;
  endfunction

  task automatic clear_logs();
    req_log.delete();
    got_pc.delete();
    got_data.delete();
  endtask

  // Returns at the negedge where reset is released (LOAD cycle follows).
  task automatic do_reset();
    rst            = 1'b0;
    mute           = 1'b0;
    pend           = 1'b0;
    mem_rvalid     = 1'b0;
    mem_rdata      = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    repeat (2) @(negedge clk);
    clear_logs();
    rst = 1'b1;
  endtask

  task automatic wait_deliv(input string tag, input int n, input int budget);
    int b = budget;
    while (got_pc.size() < n && b > 0) begin
      @(negedge clk);
      b--;
    end
    check({tag, "_count"}, 64'(got_pc.size()), 64'(n));
  endtask

  initial begin
    logic [PC_W-1:0] wrap_pc [4];
    int b;
    wrap_pc = '{8'hFE, 8'hFF, 8'h00, 8'h01};

    rst = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b1;

    // Reset values, before and after a clock edge under reset
    #2;
    check("rst_mem_req", 64'(mem_req), 0);
    check("rst_mem_addr", 64'(mem_addr), 0);
    check("rst_valid", 64'(instr_valid), 0);
    check("rst_data", 64'(instr_data), 0);
    check("rst_pc", 64'(instr_pc), 0);
    check("rst_count", 64'(q_count), 0);
    @(posedge clk); #1;
    check("rst_edge_req", 64'(mem_req), 0);

    // Startup: LOAD cycle, request at edge 2, 1-cycle memory
    lat = 1; instr_ready = 1'b1;
    do_reset();
    #1 check("load_no_req", 64'(mem_req), 0);
    @(negedge clk); #1;
    check("first_req", 64'(mem_req), 1);
    check("first_addr", 64'(mem_addr), 0);
    @(negedge clk); #1;
    check("rsp_cycle_rvalid", 64'(mem_rvalid), 1);
    check("rsp_cycle_valid", 64'(instr_valid), 0);
    @(negedge clk); #1;
    check("head_valid", 64'(instr_valid), 1);
    check("head_pc0", 64'(instr_pc), 0);
    check("head_data0", 64'(instr_data), 64'h0000_0000_A000_0000);
    wait_deliv("startup", 4, 40);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("startup_pc%0d", i), pc_at(i), 64'(i));
      check($sformatf("startup_data%0d", i), data_at(i), 64'(32'hA000_0000 + 32'(i)));
    end

    // Backpressure fill with DEPTH=2
    instr_ready = 1'b0;
    do_reset();
    repeat (12) @(negedge clk);
    #1;
    check("bp_req_count", 64'(req_log.size()), 2);
    check("bp_req0", req_at(0), 0);
    check("bp_req1", req_at(1), 1);
    check("bp_count", 64'(q_count), 2);
    check("bp_no_req", 64'(mem_req), 0);
    check("bp_head_pc", 64'(instr_pc), 0);
    check("bp_head_data", 64'(instr_data), 64'h0000_0000_A000_0000);
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    #1;
    check("bp_pop_count", 64'(q_count), 1);
    check("bp_pop_head", 64'(instr_pc), 1);
    check("bp_pop_data", 64'(instr_data), 64'h0000_0000_A000_0001);
    check("bp_refill_req", 64'(mem_req), 1);
    check("bp_refill_addr", 64'(mem_addr), 2);
    repeat (3) @(negedge clk);
    #1;
    check("bp_req_total", 64'(req_log.size()), 3);
    check("bp_req2", req_at(2), 2);
    check("bp_refill_count", 64'(q_count), 2);
    check("bp_deliv", 64'(got_pc.size()), 1);
    check("bp_deliv_pc", pc_at(0), 0);

    // Redirect while the read for addr 5 is in flight (3-cycle memory)
    lat = 3; instr_ready = 1'b1;
    do_reset();
    b = 200;
    while (!(mem_req && mem_addr == 16'd5) && b > 0) begin
      @(negedge clk); #1;
      b--;
    end
    check("rd_addr5_seen", 64'(mem_req && mem_addr == 16'd5), 1);
    instr_ready = 1'b0;
    @(negedge clk); #1;
    check("rd_pre_count", 64'(q_count), 1);
    check("rd_pre_req", 64'(mem_req), 0);
    redirect_valid = 1'b1; redirect_pc = 8'h40;
    clear_logs();
    @(negedge clk);
    redirect_valid = 1'b0; instr_ready = 1'b1;
    #1;
    check("rd_flush_count", 64'(q_count), 0);
    check("rd_flush_valid", 64'(instr_valid), 0);
    check("rd_waiting", 64'(mem_req), 0);
    wait_deliv("rd", 1, 40);
    check("rd_first_req", req_at(0), 64'h40);
    check("rd_first_pc", pc_at(0), 64'h40);
    check("rd_first_data", data_at(0), 64'h0000_0000_A000_0040);

    // Redirect, pop and response all in one cycle
    lat = 1; instr_ready = 1'b0;
    do_reset();
    b = 20;
    while (!(mem_rvalid && q_count == 4'd1) && b > 0) begin
      @(negedge clk); #1;
      b--;
    end
    check("sim_setup", 64'(mem_rvalid && q_count == 4'd1), 1);
    redirect_valid = 1'b1; redirect_pc = 8'h80; instr_ready = 1'b1;
    clear_logs();
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    check("sim_count", 64'(q_count), 0);
    check("sim_valid", 64'(instr_valid), 0);
    check("sim_restart_req", 64'(mem_req), 1);
    check("sim_restart_addr", 64'(mem_addr), 64'h80);
    wait_deliv("sim", 1, 20);
    check("sim_first_pc", pc_at(0), 64'h80);
    check("sim_first_data", data_at(0), 64'h0000_0000_A000_0080);

    // PC wrap, with the redirect landing in the LOAD cycle
    lat = 1; instr_ready = 1'b1;
    do_reset();
    redirect_valid = 1'b1; redirect_pc = 8'hFE;
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    check("wrap_first_req", 64'(mem_req), 1);
    check("wrap_first_addr", 64'(mem_addr), 64'hFE);
    wait_deliv("wrap", 4, 40);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("wrap_pc%0d", i), pc_at(i), 64'(wrap_pc[i]));
      check($sformatf("wrap_data%0d", i), data_at(i), 64'(32'hA000_0000 + 32'(wrap_pc[i])));
    end

    // Async reset while WAITing with one queued entry, then a stale response
    lat = 1; instr_ready = 1'b0;
    do_reset();
    b = 20;
    while (!(mem_req && q_count == 4'd1) && b > 0) begin
      @(negedge clk); #1;
      b--;
    end
    check("ar_setup", 64'(mem_req && q_count == 4'd1), 1);
    mute = 1'b1;
    @(negedge clk); #1;
    check("ar_pre_count", 64'(q_count), 1);
    check("ar_pre_addr", 64'(mem_addr), 1);
    #1 rst = 1'b0;
    #1;
    check("ar_valid", 64'(instr_valid), 0);
    check("ar_count", 64'(q_count), 0);
    check("ar_req", 64'(mem_req), 0);
    check("ar_addr", 64'(mem_addr), 0);
    check("ar_data", 64'(instr_data), 0);
    @(negedge clk);
    rst = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF; instr_ready = 1'b1;
    clear_logs();
    @(negedge clk);
    mem_rvalid = 1'b0; pend = 1'b0; mute = 1'b0;
    #1;
    check("ar_stale_count", 64'(q_count), 0);
    check("ar_restart_req", 64'(mem_req), 1);
    check("ar_restart_addr", 64'(mem_addr), 0);
    wait_deliv("ar", 2, 20);
    check("ar_pc0", pc_at(0), 0);
    check("ar_data0", data_at(0), 64'h0000_0000_A000_0000);
    check("ar_pc1", pc_at(1), 1);
    check("ar_data1", data_at(1), 64'h0000_0000_A000_0001);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
